// File: rtl/rx_acq_sequencer.sv
// Frame sequencer for the shared receiver ADC: converts channels 0..3 each frame, publishes rx1..rx4
// together and strobes endata. Define RXACQ_ERRCNT_EN to include the saturating timeout counter.
`timescale 1ns/1ps
module rx_acq_sequencer #(
  parameter int FRAMEDIV    = 20,
  parameter int ADC_TIMEOUT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  adc_sel,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] rx1,
  output logic [11:0] rx2,
  output logic [11:0] rx3,
  output logic [11:0] rx4,
  output logic        endata,
  output logic [7:0]  err_count
);
  localparam int FCW = $clog2(FRAMEDIV);
  localparam int WCW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMEDIV - 1);
  localparam logic [FCW-1:0] FC_PUB   = FCW'(FRAMEDIV - 3);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(ADC_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_PUBLISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [FCW-1:0]   fc_q, fc_d;
  logic [1:0]       ch_q, ch_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [11:0]      shadow_q [4];
  logic [11:0]      shadow_d [4];
  logic [11:0]      rx_q [4];
  logic [11:0]      rx_d [4];
  logic [1:0]       sel_q, sel_d;
  logic             start_q, start_d;
  logic             endata_q, endata_d;
  logic             step_s;

  // Next-state logic; registered outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    wcnt_d   = wcnt_q;
    shadow_d = shadow_q;
    step_s   = 1'b0;
    fc_d     = (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);

    case (state_q)
      S_IDLE: begin
        if ((fc_q == '0) && enable) begin
          ch_d    = 2'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        wcnt_d  = WCW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done strobe on the final wait cycle still counts as a good conversion.
        if (adc_done) begin
          shadow_d[ch_q] = adc_data;
          step_s         = 1'b1;
        end else if (wcnt_q == WAIT_MAX) begin
          step_s = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
        if (step_s) begin
          if (ch_q == 2'd3) begin
            state_d = S_HOLD;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = S_START;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (fc_q == FC_PUB) begin
          state_d = S_PUBLISH;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    sel_d    = ch_d;
    start_d  = (state_d == S_START);
    endata_d = (state_d == S_PUBLISH);
    if (state_d == S_PUBLISH) begin
      rx_d = shadow_q;
    end else begin
      rx_d = rx_q;
    end
  end

  // State, frame counter and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fc_q     <= '0;
      ch_q     <= 2'd0;
      wcnt_q   <= '0;
      shadow_q <= '{default: 12'd0};
      rx_q     <= '{default: 12'd0};
      sel_q    <= 2'd0;
      start_q  <= 1'b0;
      endata_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      ch_q     <= ch_d;
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
      rx_q     <= rx_d;
      sel_q    <= sel_d;
      start_q  <= start_d;
      endata_q <= endata_d;
    end
  end

  assign adc_sel   = sel_q;
  assign adc_start = start_q;
  assign endata    = endata_q;
  assign rx1       = rx_q[0];
  assign rx2       = rx_q[1];
  assign rx3       = rx_q[2];
  assign rx4       = rx_q[3];

`ifdef RXACQ_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       timeout_s;

  assign timeout_s = (state_q == S_WAIT) && !adc_done && (wcnt_q == WAIT_MAX);

  // Saturating count of abandoned conversions.
  always_comb begin
    if (timeout_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_rx_acq_sequencer.sv
// Directed bench for rx_acq_sequencer with a small ADC responder model and hand-computed expectations.
`timescale 1ns/1ps
module tb_rx_acq_sequencer;
  localparam int FRAMEDIV = 20;
`ifdef RXACQ_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  adc_sel;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] rx1, rx2, rx3, rx4;
  logic        endata;
  logic [7:0]  err_count;

  logic        model_done = 1'b0;
  logic [11:0] model_data = 12'd0;
  logic        spur_done  = 1'b0;
  logic [11:0] spur_data  = 12'd0;
  int          lat [4];
  logic [11:0] vals [4];
  int          pend_cnt = 0;
  logic [1:0]  pend_ch  = 2'd0;

  int          tb_fc  = 0;
  int          tb_cyc = 0;
  int          rel_cyc = 0;
  int          starts [$];
  logic [1:0]  sels [$];
  int          end_cyc [$];
  logic [47:0] end_rx = 48'd0;
  int          bad_end = 0;
  int          errors = 0;
  int          checks = 0;

  assign adc_done = model_done | spur_done;
  assign adc_data = spur_done ? spur_data : model_data;

  rx_acq_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .adc_sel   (adc_sel),
    .adc_start (adc_start),
    .adc_done  (adc_done),
    .adc_data  (adc_data),
    .rx1       (rx1),
    .rx2       (rx2),
    .rx3       (rx3),
    .rx4       (rx4),
    .endata    (endata),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Reference frame position: 0 in the cycle after any reset edge, then wraps every FRAMEDIV.
  always @(posedge clock) begin
    tb_cyc = tb_cyc + 1;
    if (!reset) tb_fc = 0;
    else        tb_fc = (tb_fc == FRAMEDIV - 1) ? 0 : tb_fc + 1;
  end

  // ADC responder (lat = WAIT cycle of the done strobe, 0 = never) plus event recorder.
  always @(negedge clock) begin
    model_done = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        model_done = 1'b1;
        model_data = vals[pend_ch];
      end
    end
    if (adc_start) begin
      pend_ch  = adc_sel;
      pend_cnt = lat[adc_sel];
      starts.push_back(tb_fc);
      sels.push_back(adc_sel);
    end
    if (endata) begin
      end_cyc.push_back(tb_cyc);
      end_rx = {rx1, rx2, rx3, rx4};
      if (tb_fc != FRAMEDIV - 2) bad_end = bad_end + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_err(input int n);
    return ERR_EN ? 8'(n) : 8'd0;
  endfunction

  task automatic set_adc(input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                         input logic [11:0] v3, input int l0, input int l1, input int l2, input int l3);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    lat[0]  = l0; lat[1]  = l1; lat[2]  = l2; lat[3]  = l3;
  endtask

  task automatic clear_mon();
    starts.delete();
    sels.delete();
    end_cyc.delete();
    end_rx = 48'd0;
  endtask

  task automatic wait_fc(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n = n + 1;
    end while ((tb_fc != target) && (n < 2 * FRAMEDIV));
    if (tb_fc != target) check_val("wait_fc", 64'(tb_fc), 64'(target));
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    set_adc(12'h123, 12'h456, 12'hF00, 12'h7FF, 1, 1, 1, 1);

    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_ctl", 64'({adc_sel, adc_start, endata, err_count}), 64'd0);
    check_val("rst_rx", 64'({rx1, rx2, rx3, rx4}), 64'd0);

    // Nominal conversion, startup latency and frame period
    reset   = 1'b1;
    rel_cyc = tb_cyc;
    clear_mon();
    repeat (40) @(negedge clock);
    check_val("nom_starts_n", 64'(starts.size()), 64'd8);
    check_val("nom_start_fc", 64'({8'(starts[0]), 8'(starts[1]), 8'(starts[2]), 8'(starts[3])}),
              64'({8'd1, 8'd3, 8'd5, 8'd7}));
    check_val("nom_sel", 64'({sels[0], sels[1], sels[2], sels[3]}), 64'({2'd0, 2'd1, 2'd2, 2'd3}));
    check_val("nom_end_n", 64'(end_cyc.size()), 64'd2);
    check_val("startup", 64'(end_cyc[0] - rel_cyc), 64'd18);
    check_val("period", 64'(end_cyc[1] - end_cyc[0]), 64'd20);
    check_val("nom_rx", 64'(end_rx), 64'({12'h123, 12'h456, 12'hF00, 12'h7FF}));
    check_val("nom_err", 64'(err_count), 64'd0);

    // Timeout on channel 2: rx3 keeps last value, rx4 updates
    set_adc(12'h123, 12'h456, 12'h999, 12'h001, 1, 1, 0, 1);
    clear_mon();
    repeat (20) @(negedge clock);
    check_val("to_end_n", 64'(end_cyc.size()), 64'd1);
    check_val("to_rx", 64'(end_rx), 64'({12'h123, 12'h456, 12'hF00, 12'h001}));
    check_val("to_start3", 64'(starts[3]), 64'd9);
    check_val("to_err1", 64'(err_count), 64'(exp_err(1)));
    repeat (20) @(negedge clock);
    check_val("to_err2", 64'(err_count), 64'(exp_err(2)));

    // Done on the last WAIT cycle wins over the timeout
    set_adc(12'h123, 12'h456, 12'h5A5, 12'h001, 1, 1, 3, 1);
    clear_mon();
    repeat (20) @(negedge clock);
    check_val("co_rx", 64'(end_rx), 64'({12'h123, 12'h456, 12'h5A5, 12'h001}));
    check_val("co_err", 64'(err_count), 64'(exp_err(2)));
    check_val("co_start3", 64'(starts[3]), 64'd9);

    // Enable dropped mid-frame: frame completes, next one is silent
    set_adc(12'h111, 12'h222, 12'h333, 12'h444, 1, 1, 1, 1);
    clear_mon();
    wait_fc(5);
    enable = 1'b0;
    wait_fc(0);
    check_val("en_end_n", 64'(end_cyc.size()), 64'd1);
    check_val("en_rx", 64'(end_rx), 64'({12'h111, 12'h222, 12'h333, 12'h444}));
    check_val("en_starts_n", 64'(starts.size()), 64'd4);
    set_adc(12'h999, 12'h999, 12'h999, 12'h999, 1, 1, 1, 1);
    clear_mon();
    repeat (20) @(negedge clock);
    check_val("off_starts_n", 64'(starts.size()), 64'd0);
    check_val("off_end_n", 64'(end_cyc.size()), 64'd0);
    check_val("off_rx", 64'({rx1, rx2, rx3, rx4}), 64'({12'h111, 12'h222, 12'h333, 12'h444}));

    // Spurious done in IDLE and HOLD
    wait_fc(15);
    spur_data = 12'hAAA;
    spur_done = 1'b1;
    @(negedge clock);
    spur_done = 1'b0;
    enable    = 1'b1;
    check_val("idle_spur_rx", 64'({rx1, rx2, rx3, rx4}), 64'({12'h111, 12'h222, 12'h333, 12'h444}));
    set_adc(12'h010, 12'h020, 12'h030, 12'h040, 1, 1, 1, 1);
    clear_mon();
    wait_fc(12);
    spur_done = 1'b1;
    @(negedge clock);
    spur_done = 1'b0;
    wait_fc(0);
    check_val("spur_end_n", 64'(end_cyc.size()), 64'd1);
    check_val("spur_rx", 64'(end_rx), 64'({12'h010, 12'h020, 12'h030, 12'h040}));

    // Reset mid-frame at fc=9
    wait_fc(9);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_val("mr_ctl", 64'({adc_sel, adc_start, endata, err_count}), 64'd0);
    check_val("mr_rx", 64'({rx1, rx2, rx3, rx4}), 64'd0);
    rel_cyc = tb_cyc;
    clear_mon();
    repeat (20) @(negedge clock);
    check_val("mr_end_n", 64'(end_cyc.size()), 64'd1);
    check_val("mr_lat", 64'(end_cyc[0] - rel_cyc), 64'd18);
    check_val("mr_rx2", 64'(end_rx), 64'({12'h010, 12'h020, 12'h030, 12'h040}));

    // Error counter saturation over 260 timeout frames
    set_adc(12'h010, 12'h020, 12'h777, 12'h040, 1, 1, 0, 1);
    clear_mon();
    repeat (254 * FRAMEDIV) @(negedge clock);
    check_val("sat_err254", 64'(err_count), 64'(exp_err(254)));
    repeat (6 * FRAMEDIV) @(negedge clock);
    check_val("sat_err255", 64'(err_count), 64'(exp_err(255)));
    check_val("sat_end_n", 64'(end_cyc.size()), 64'd260);
    check_val("sat_rx", 64'(end_rx), 64'({12'h010, 12'h020, 12'h030, 12'h040}));

    check_val("endata_fc", 64'(bad_end), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
